// File: rtl/mod_sqr_chain_pkg.sv
// Shared widths and FSM encoding for the iterated modular squaring engine.
package mod_sqr_chain_pkg;

    localparam int unsigned DEF_W  = 128;
    localparam int unsigned DEF_TW = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic int unsigned bit_idx_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved multiply-reduce: p = a*b mod n, one multiplier bit per cycle, MSB first.
module mod_mul_serial
    import mod_sqr_chain_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] p_o,
    output logic         done_c
);

    localparam int unsigned BW = bit_idx_w(W);
    localparam int unsigned AW = W + 2;

    logic [W-1:0]  acc_q, acc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          run_q, run_d;
    logic [AW-1:0] n_ext, sum_c, red1_c, red2_c;

    // 2*acc + b stays below 3n, so two conditional subtractions fully reduce it.
    always_comb begin
        n_ext  = AW'(n_i);
        sum_c  = {1'b0, acc_q, 1'b0} + (a_i[bit_q] ? AW'(b_i) : AW'(0));
        red1_c = (sum_c >= n_ext) ? sum_c - n_ext : sum_c;
        red2_c = (red1_c >= n_ext) ? red1_c - n_ext : red1_c;
    end

    always_comb begin
        acc_d = acc_q;
        bit_d = bit_q;
        run_d = run_q;
        if (go_i) begin
            acc_d = '0;
            bit_d = BW'(W - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = red2_c[W-1:0];
            bit_d = bit_q - BW'(1);
            if (bit_q == '0) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            bit_q <= '0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
            run_q <= run_d;
        end
    end

    assign p_o    = acc_q;
    assign done_c = run_q && (bit_q == '0);

endmodule

// File: rtl/mod_sqr_chain.sv
// Iterated modular squaring: res = x^(2^t) mod n, with start-pulse / valid handshake.
module mod_sqr_chain
    import mod_sqr_chain_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned TW = DEF_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  n,
    input  logic [TW-1:0] t,
    output logic [W-1:0]  res,
    output logic          valid,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [W-1:0]  xr_q, xr_d;
    logic [W-1:0]  nr_q, nr_d;
    logic [TW-1:0] tr_q, tr_d;
    logic [W-1:0]  res_q, res_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          go_c;
    logic          mul_done_c;
    logic [W-1:0]  prod;

    mod_mul_serial #(.W(W)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .go_i   (go_c),
        .a_i    (xr_q),
        .b_i    (xr_q),
        .n_i    (nr_q),
        .p_o    (prod),
        .done_c (mul_done_c)
    );

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        nr_d    = nr_q;
        tr_d    = tr_q;
        res_d   = res_q;
        go_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xr_d    = x;
                    nr_d    = n;
                    tr_d    = t;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (nr_q < W'(2)) begin
                    res_d   = '0;
                    state_d = S_DONE;
                end else if (tr_q == '0) begin
                    res_d   = xr_q;
                    state_d = S_DONE;
                end else begin
                    go_c    = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_done_c) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                xr_d = prod;
                tr_d = tr_q - TW'(1);
                // tr_q is nonzero here, so the decrement never wraps.
                if (tr_q == TW'(1)) begin
                    res_d   = prod;
                    state_d = S_DONE;
                end else begin
                    go_c    = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d == S_LOAD) || (state_d == S_MUL) || (state_d == S_NEXT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            xr_q    <= '0;
            nr_q    <= '0;
            tr_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            nr_q    <= nr_d;
            tr_q    <= tr_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign res   = res_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mod_sqr_chain.sv
// Directed bench for mod_sqr_chain: vector table plus handshake and reset sequences.
module tb_mod_sqr_chain;

    localparam int unsigned W      = 128;
    localparam int unsigned TW     = 32;
    localparam int          BUDGET = 400;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  x;
    logic [W-1:0]  n;
    logic [TW-1:0] t;
    logic [W-1:0]  res;
    logic          valid;
    logic          busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  n;
        logic [TW-1:0] t;
        logic [W-1:0]  exp_res;
        int            exp_lat;
    } vec_t;

    vec_t vecs [5];

    mod_sqr_chain #(.W(W), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .n     (n),
        .t     (t),
        .res   (res),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Launch one job, count edges to valid, optionally poke start mid-job and during the valid cycle.
    task automatic run_job(input logic [W-1:0] xi, input logic [W-1:0] ni, input logic [TW-1:0] ti,
                           input int inject_at, input bit start_on_valid,
                           output int lat, output logic [W-1:0] r);
        int  cyc;
        bit  got;
        @(negedge clk);
        x     = xi;
        n     = ni;
        t     = ti;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = '1;
        n     = '0;
        t     = '1;
        check("busy_after_start", W'(busy), W'(1));
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == inject_at);
            if (start) begin
                x = W'(3);
                n = W'(7);
                t = TW'(0);
            end
            if (valid) got = 1'b1;
        end
        start = 1'b0;
        check("valid_seen_within_budget", W'(got), W'(1));
        lat = cyc;
        r   = res;
        if (start_on_valid) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("valid_single_pulse", W'(valid), W'(0));
        check("busy_low_after_valid", W'(busy), W'(0));
        check("res_held_after_valid", res, r);
    endtask

    initial begin
        int            lat;
        logic [W-1:0]  r;
        bit            extra;

        vecs[0] = '{x: W'(5), n: W'(13), t: TW'(1), exp_res: W'(12), exp_lat: 130};
        vecs[1] = '{x: W'(3), n: W'(13), t: TW'(2), exp_res: W'(3),  exp_lat: 259};
        vecs[2] = '{x: W'(1) << 64, n: (W'(1) << 127) - W'(1), t: TW'(1), exp_res: W'(2), exp_lat: 130};
        vecs[3] = '{x: W'(7), n: W'(13), t: TW'(0), exp_res: W'(7),  exp_lat: 1};
        vecs[4] = '{x: W'(0), n: W'(1),  t: TW'(5), exp_res: W'(0),  exp_lat: 1};

        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        n     = '0;
        t     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_res", res, W'(0));
        check("reset_valid", W'(valid), W'(0));
        check("reset_busy", W'(busy), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].x, vecs[i].n, vecs[i].t, -1, (i == 0), lat, r);
            check($sformatf("vec%0d_res", i), r, vecs[i].exp_res);
            check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].exp_lat));
        end

        // Start pulse during an active job must be ignored.
        run_job(W'(5), W'(13), TW'(1), 10, 1'b0, lat, r);
        check("ignored_start_res", r, W'(12));
        check("ignored_start_latency", W'(lat), W'(130));
        extra = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (valid || busy) extra = 1'b1;
        end
        check("no_extra_job_after_ignored_start", W'(extra), W'(0));

        // Asynchronous reset in the middle of a two-squaring job.
        @(negedge clk);
        x     = W'(3);
        n     = W'(13);
        t     = TW'(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("busy_before_abort", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("abort_res", res, W'(0));
        check("abort_valid", W'(valid), W'(0));
        check("abort_busy", W'(busy), W'(0));
        extra = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (valid || busy) extra = 1'b1;
        end
        check("quiet_during_reset", W'(extra), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        extra = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (valid || busy) extra = 1'b1;
        end
        check("aborted_job_never_completes", W'(extra), W'(0));
        run_job(W'(5), W'(13), TW'(1), -1, 1'b0, lat, r);
        check("post_reset_res", r, W'(12));
        check("post_reset_latency", W'(lat), W'(130));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
